// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS-subset datapath: decodes the opcode into datapath
// controls, waits on a memory handshake, flags unsupported opcodes and counts retired instructions.
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        zf,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t      state_q, state_d;
    logic [15:0] retired_q, retired_d;
    logic        illegal_q, illegal_d;
    logic        retire;

    // The zero flag is combined with pc_write_cond outside this block.
    wire unused_zf = zf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= 16'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:    state_d = S_RWB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
        retired_d = retire ? retired_q + 16'd1 : retired_q;
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR load and PC+4 commit only in the cycle the fetch completes.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:  alu_src_b = 2'b11;
            S_MEMADR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_WB: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/controls/counters are
// queued as each instruction is scheduled, then popped and compared one cycle at a time.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        zf;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        illegal;
    logic [15:0] retired;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zf(zf), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    wire [15:0] ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    wire [36:0] obs = {state, ctl, retired, illegal};

    typedef struct packed {
        logic        mr;
        logic [5:0]  op;
        logic [36:0] exp;
    } entry_t;

    entry_t      sb[$];
    entry_t      e;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_ret = 16'd0;
    logic        exp_ill = 1'b0;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD = 6'b111111;

    task automatic push(input logic mr, input logic [5:0] op, input logic [3:0] st,
                        input logic [15:0] c);
        entry_t n;
        n.mr  = mr;
        n.op  = op;
        n.exp = {st, c, exp_ret, exp_ill};
        sb.push_back(n);
    endtask

    // Expected cycle-by-cycle trace of one instruction, with `waits` stalled memory cycles.
    task automatic push_instr(input logic [5:0] op, input int waits);
        push(1'b1, op, 4'd0, 16'h9410);
        push(1'b1, op, 4'd1, 16'h0030);
        case (op)
            OP_R: begin
                push(1'b1, op, 4'd6, 16'h0048);
                push(1'b1, op, 4'd7, 16'h0180);
                exp_ret++;
            end
            OP_LW: begin
                push(1'b1, op, 4'd2, 16'h0060);
                for (int i = 0; i < waits; i++) push(1'b0, op, 4'd3, 16'h3000);
                push(1'b1, op, 4'd3, 16'h3000);
                push(1'b1, op, 4'd4, 16'h0280);
                exp_ret++;
            end
            OP_SW: begin
                push(1'b1, op, 4'd2, 16'h0060);
                for (int i = 0; i < waits; i++) push(1'b0, op, 4'd5, 16'h2800);
                push(1'b1, op, 4'd5, 16'h2800);
                exp_ret++;
            end
            OP_BEQ: begin
                push(1'b1, op, 4'd8, 16'h4045);
                exp_ret++;
            end
            OP_J: begin
                push(1'b1, op, 4'd9, 16'h8002);
                exp_ret++;
            end
            OP_ADDI: begin
                push(1'b1, op, 4'd10, 16'h0060);
                push(1'b1, op, 4'd11, 16'h0080);
                exp_ret++;
            end
            default: begin
                exp_ill = 1'b1;
                for (int i = 0; i < 20; i++) push(1'($urandom_range(0, 1)), op, 4'd12, 16'h0000);
            end
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; opcode = OP_R; zf = 1'b0;
        #2;
        checks++;
        if ({state, retired, illegal, mem_write} !== 22'd0) begin
            errors++;
            $display("FAIL reset_async: st=%0d ret=%h ill=%b mw=%b required 0,0000,0,0",
                     state, retired, illegal, mem_write);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({state, retired, illegal} !== 21'd0) begin
            errors++;
            $display("FAIL reset_held: st=%0d ret=%h ill=%b required 0,0000,0", state, retired, illegal);
        end
        rst_n = 1'b1;
        exp_ret = 16'd0; exp_ill = 1'b0;
    endtask

    task automatic test_rtype();
        push_instr(OP_R, 0);
        push(1'b0, OP_R, 4'd0, 16'h1010);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; opcode = e.op; zf = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL rtype: got st=%0d ctl=%h ret=%h ill=%b, required st=%0d ctl=%h ret=%h ill=%b",
                         obs[36:33], obs[32:17], obs[16:1], obs[0], e.exp[36:33], e.exp[32:17], e.exp[16:1], e.exp[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_wait();
        push_instr(OP_LW, 3);
        push(1'b0, OP_R, 4'd0, 16'h1010);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; opcode = e.op; zf = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL lw_wait: got st=%0d ctl=%h ret=%h ill=%b, required st=%0d ctl=%h ret=%h ill=%b",
                         obs[36:33], obs[32:17], obs[16:1], obs[0], e.exp[36:33], e.exp[32:17], e.exp[16:1], e.exp[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_beq();
        push_instr(OP_BEQ, 0);
        push(1'b0, OP_R, 4'd0, 16'h1010);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; opcode = e.op; zf = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL beq: got st=%0d ctl=%h ret=%h ill=%b, required st=%0d ctl=%h ret=%h ill=%b",
                         obs[36:33], obs[32:17], obs[16:1], obs[0], e.exp[36:33], e.exp[32:17], e.exp[16:1], e.exp[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        push_instr(OP_SW, 0);
        push_instr(OP_J, 0);
        push_instr(OP_ADDI, 0);
        push_instr(OP_LW, 0);
        push_instr(OP_SW, 2);
        push(1'b0, OP_R, 4'd0, 16'h1010);
        push(1'b0, OP_R, 4'd0, 16'h1010);
        push_instr(OP_R, 0);
        push_instr(OP_BEQ, 0);
        push(1'b0, OP_R, 4'd0, 16'h1010);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; opcode = e.op; zf = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL back_to_back: got st=%0d ctl=%h ret=%h ill=%b, required st=%0d ctl=%h ret=%h ill=%b",
                         obs[36:33], obs[32:17], obs[16:1], obs[0], e.exp[36:33], e.exp[32:17], e.exp[16:1], e.exp[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        dut.retired_q = 16'hFFFF;
        exp_ret = 16'hFFFF;
        push_instr(OP_J, 0);
        push(1'b0, OP_R, 4'd0, 16'h1010);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; opcode = e.op; zf = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL wrap: got st=%0d ctl=%h ret=%h ill=%b, required st=%0d ctl=%h ret=%h ill=%b",
                         obs[36:33], obs[32:17], obs[16:1], obs[0], e.exp[36:33], e.exp[32:17], e.exp[16:1], e.exp[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_trap();
        push_instr(OP_BAD, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; opcode = e.op; zf = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL trap: got st=%0d ctl=%h ret=%h ill=%b, required st=%0d ctl=%h ret=%h ill=%b",
                         obs[36:33], obs[32:17], obs[16:1], obs[0], e.exp[36:33], e.exp[32:17], e.exp[16:1], e.exp[0]);
            end
            @(negedge clk);
        end
        opcode = OP_R;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, retired, illegal} !== 21'd0) begin
            errors++;
            $display("FAIL trap_clear: st=%0d ret=%h ill=%b required 0,0000,0", state, retired, illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_ret = 16'd0; exp_ill = 1'b0;
    endtask

    task automatic test_async_reset_memwr();
        push(1'b1, OP_SW, 4'd0, 16'h9410);
        push(1'b1, OP_SW, 4'd1, 16'h0030);
        push(1'b1, OP_SW, 4'd2, 16'h0060);
        push(1'b0, OP_SW, 4'd5, 16'h2800);
        push(1'b0, OP_SW, 4'd5, 16'h2800);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; opcode = e.op; zf = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL memwr_wait: got st=%0d ctl=%h ret=%h ill=%b, required st=%0d ctl=%h ret=%h ill=%b",
                         obs[36:33], obs[32:17], obs[16:1], obs[0], e.exp[36:33], e.exp[32:17], e.exp[16:1], e.exp[0]);
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, mem_write, retired} !== {4'd0, 1'b0, exp_ret}) begin
            errors++;
            $display("FAIL memwr_async_reset: st=%0d mw=%b ret=%h required 0,0,%h",
                     state, mem_write, retired, exp_ret);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_back_to_back();
        test_wrap();
        test_trap();
        test_async_reset_memwr();
        test_rtype();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion before 200000");
        $fatal(1, "timeout");
    end

endmodule
